// File: rtl/alu_div_seq.sv
// Multicycle signed 32-bit restoring divider: one 33-bit trial subtract per cycle,
// quotient truncated toward zero, remainder sign follows the dividend.
module alu_div_seq #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic             start_q,  start_d;
    logic [WIDTH-1:0] a_raw_q,  a_raw_d;
    logic [WIDTH-1:0] b_raw_q,  b_raw_d;
    logic [WIDTH-1:0] mag_b_q,  mag_b_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic [WIDTH-1:0] r_q,      r_d;
    logic             qneg_q,   qneg_d;
    logic             rneg_q,   rneg_d;
    logic             dbz_q,    dbz_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic             exc_q,    exc_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   r_sh, trial;
    logic [WIDTH-1:0] q_sh, quo_fix, rem_fix;

    // Magnitudes are unsigned, so |-2^31| = 0x80000000 survives the wrap.
    assign mag_a   = a_raw_q[WIDTH-1] ? -a_raw_q : a_raw_q;
    assign mag_b   = b_raw_q[WIDTH-1] ? -b_raw_q : b_raw_q;
    assign r_sh    = {r_q, q_q[WIDTH-1]};
    assign q_sh    = {q_q[WIDTH-2:0], 1'b0};
    assign trial   = r_sh - {1'b0, mag_b_q};
    assign quo_fix = qneg_q ? -q_q : q_q;
    assign rem_fix = rneg_q ? -r_q : r_q;

    // The start edge only captures raw operands; the following cycle forms
    // magnitudes and signs, which keeps the operand inputs off the subtractor path.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no branch can infer a latch.
        state_d  = state_q;
        start_d  = 1'b0;
        a_raw_d  = a_raw_q;
        b_raw_d  = b_raw_q;
        mag_b_d  = mag_b_q;
        q_d      = q_q;
        r_d      = r_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        exc_d    = exc_q;

        if (ctrl_DIV) begin
            a_raw_d = data_operandA;
            b_raw_d = data_operandB;
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (start_q) begin
            mag_b_d = mag_b;
            qneg_d  = a_raw_q[WIDTH-1] ^ b_raw_q[WIDTH-1];
            rneg_d  = a_raw_q[WIDTH-1];
            dbz_d   = (b_raw_q == '0);
            r_d     = '0;
            q_d     = mag_a;
            cnt_d   = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!trial[WIDTH]) begin
                        r_d = trial[WIDTH-1:0];
                        q_d = {q_sh[WIDTH-1:1], 1'b1};
                    end else begin
                        r_d = r_sh[WIDTH-1:0];
                        q_d = q_sh;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERS - 1)) state_d = S_FIX;
                end
                S_FIX: begin
                    result_d = dbz_q ? '0 : quo_fix;
                    rem_d    = dbz_q ? '0 : rem_fix;
                    exc_d    = dbz_q;
                    state_d  = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            a_raw_q  <= '0;
            b_raw_q  <= '0;
            mag_b_q  <= '0;
            q_q      <= '0;
            r_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q  <= state_d;
            start_q  <= start_d;
            a_raw_q  <= a_raw_d;
            b_raw_q  <= b_raw_d;
            mag_b_q  <= mag_b_d;
            q_q      <= q_d;
            r_q      <= r_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = rem_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);

endmodule
